// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - 8-digit 7-seg scan scheduler (score/combo/banner/End screens)
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_display_scheduler #(
    parameter int SCAN_DIV   = 16384,
    parameter int BLANK_CYC  = 64,
    parameter int BANNER_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_judge,
    input  logic [15:0] i_score_bcd,
    input  logic [11:0] i_combo_bcd,
    input  logic        i_game_over,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_com,
    output logic        o_busy
);
    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int TMR_W = $clog2(BANNER_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(BANNER_CYC - 1);

    typedef enum logic [1:0] {S_SCORE = 2'd0, S_BANNER = 2'd1, S_FINAL = 2'd2} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_slot_cnt;
    logic [2:0]       r_digit_idx;
    logic [1:0]       r_prev_judge;
    logic [1:0]       r_glyph;
    logic [TMR_W-1:0] r_banner_timer;
    logic [15:0]      r_score_snap;
    logic [11:0]      r_combo_snap;

    logic        w_event;
    logic        w_load;
    logic        w_slot_wrap;
    logic [15:0] w_score;
    logic [11:0] w_combo;
    logic [31:0] w_banner;
    logic [7:0]  w_seg_next;
    logic [7:0]  w_com_next;
    logic        w_lz_s3, w_lz_s2, w_lz_s1, w_lz_c6, w_lz_c5;

    function automatic logic [7:0] f_bcd_glyph(input logic [3:0] d);
        case (d)
            4'd0:    f_bcd_glyph = 8'hC0;
            4'd1:    f_bcd_glyph = 8'hF9;
            4'd2:    f_bcd_glyph = 8'hA4;
            4'd3:    f_bcd_glyph = 8'hB0;
            4'd4:    f_bcd_glyph = 8'h99;
            4'd5:    f_bcd_glyph = 8'h92;
            4'd6:    f_bcd_glyph = 8'h82;
            4'd7:    f_bcd_glyph = 8'hF8;
            4'd8:    f_bcd_glyph = 8'h80;
            4'd9:    f_bcd_glyph = 8'h90;
            default: f_bcd_glyph = 8'hFF;
        endcase
    endfunction

    assign w_event     = (i_judge != 2'b00) && (i_judge != r_prev_judge);
    assign w_load      = w_event && !i_game_over && (r_state != S_FINAL);
    assign w_slot_wrap = (r_slot_cnt == CNT_LAST);

    // The snapshot register loads at count 0, so bypass it in that one cycle.
    assign w_score = (r_slot_cnt == '0) ? i_score_bcd : r_score_snap;
    assign w_combo = (r_slot_cnt == '0) ? i_combo_bcd : r_combo_snap;

`ifdef SEG_LZ_BLANK_EN
    assign w_lz_s3 = (w_score[15:12] == 4'd0);
    assign w_lz_s2 = w_lz_s3 && (w_score[11:8] == 4'd0);
    assign w_lz_s1 = w_lz_s2 && (w_score[7:4] == 4'd0);
    assign w_lz_c6 = (w_combo[11:8] == 4'd0);
    assign w_lz_c5 = w_lz_c6 && (w_combo[7:4] == 4'd0);
`else
    assign w_lz_s3 = 1'b0;
    assign w_lz_s2 = 1'b0;
    assign w_lz_s1 = 1'b0;
    assign w_lz_c6 = 1'b0;
    assign w_lz_c5 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_SCORE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_game_over) begin
            w_next_state = S_FINAL;
        end else begin
            case (r_state)
                S_SCORE:  if (w_event) w_next_state = S_BANNER;
                S_BANNER: if (!w_event && (r_banner_timer == '0)) w_next_state = S_SCORE;
                S_FINAL:  w_next_state = S_SCORE;
                default:  w_next_state = S_SCORE;
            endcase
        end
    end

    // Upper-half words are laid out digit7..digit4, MSB byte first.
    always_comb begin
        w_banner = 32'hFFFF_FFFF;
        if (r_state == S_FINAL) begin
            w_banner = 32'h86AB_A1FF;
        end else begin
            case (r_glyph)
                2'b11:   w_banner = 32'h8C86_AF8E;
                2'b10:   w_banner = 32'hC2C0_C0A1;
                2'b01:   w_banner = 32'h8388_A1FF;
                default: w_banner = 32'hFFFF_FFFF;
            endcase
        end
    end

    always_comb begin
        w_seg_next = 8'hFF;
        w_com_next = 8'hFF;
        if (r_slot_cnt >= CNT_BLANK) begin
            w_com_next = ~(8'h01 << r_digit_idx);
            case (r_digit_idx)
                3'd0: w_seg_next = f_bcd_glyph(w_score[3:0]);
                3'd1: w_seg_next = w_lz_s1 ? 8'hFF : f_bcd_glyph(w_score[7:4]);
                3'd2: w_seg_next = w_lz_s2 ? 8'hFF : f_bcd_glyph(w_score[11:8]);
                3'd3: w_seg_next = w_lz_s3 ? 8'hFF : f_bcd_glyph(w_score[15:12]);
                3'd4: w_seg_next = (r_state == S_SCORE) ? f_bcd_glyph(w_combo[3:0]) : w_banner[7:0];
                3'd5: w_seg_next = (r_state == S_SCORE) ? (w_lz_c5 ? 8'hFF : f_bcd_glyph(w_combo[7:4]))
                                                        : w_banner[15:8];
                3'd6: w_seg_next = (r_state == S_SCORE) ? (w_lz_c6 ? 8'hFF : f_bcd_glyph(w_combo[11:8]))
                                                        : w_banner[23:16];
                3'd7: w_seg_next = (r_state == S_SCORE) ? 8'hFF : w_banner[31:24];
                default: w_seg_next = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_cnt     <= '0;
            r_digit_idx    <= '0;
            r_prev_judge   <= '0;
            r_glyph        <= '0;
            r_banner_timer <= '0;
            r_score_snap   <= '0;
            r_combo_snap   <= '0;
            o_seg          <= 8'hFF;
            o_com          <= 8'hFF;
            o_busy         <= 1'b0;
        end else begin
            r_prev_judge <= i_judge;
            if (w_slot_wrap) begin
                r_slot_cnt  <= '0;
                r_digit_idx <= r_digit_idx + 3'd1;
            end else begin
                r_slot_cnt <= r_slot_cnt + CNT_W'(1);
            end
            if (r_slot_cnt == '0) begin
                r_score_snap <= i_score_bcd;
                r_combo_snap <= i_combo_bcd;
            end
            if (w_load) begin
                r_banner_timer <= TMR_LOAD;
                r_glyph        <= i_judge;
            end else if ((r_state == S_BANNER) && (r_banner_timer != '0)) begin
                r_banner_timer <= r_banner_timer - TMR_W'(1);
            end
            o_seg  <= w_seg_next;
            o_com  <= w_com_next;
            o_busy <= (w_next_state == S_BANNER);
        end
    end
endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb/tb_seg_display_scheduler.sv - bench for seg_display_scheduler
// Cycle-time model compared every cycle plus directed literal checks.
module tb_seg_display_scheduler;
    localparam int SD  = 16;
    localparam int BLK = 2;
    localparam int BAN = 200;
`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_judge;
    logic [15:0] i_score_bcd;
    logic [11:0] i_combo_bcd;
    logic        i_game_over;
    logic [7:0]  o_seg;
    logic [7:0]  o_com;
    logic        o_busy;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    seg_display_scheduler #(.SCAN_DIV(SD), .BLANK_CYC(BLK), .BANNER_CYC(BAN)) dut (
        .clk(clk), .rst(rst), .i_judge(i_judge), .i_score_bcd(i_score_bcd),
        .i_combo_bcd(i_combo_bcd), .i_game_over(i_game_over),
        .o_seg(o_seg), .o_com(o_com), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    logic [7:0] glyph_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s at %0t: got %h want %h", nm, $time, got, want);
        end
    endtask

    // Model: time t since reset gives slot and digit; banner lasts until a recorded end time.
    int          t;
    int          m_state;
    int          m_end;
    logic [1:0]  m_prev, m_glyph;
    logic [15:0] m_ssnap;
    logic [11:0] m_csnap;
    logic [7:0]  e_seg, e_com;
    logic        e_busy;

    function automatic logic [7:0] bcd_g(input logic [3:0] n);
        return (n > 4'd9) ? 8'hFF : glyph_tbl[n];
    endfunction

    function automatic logic [7:0] model_glyph(input int dig, input int st, input logic [1:0] gl,
                                                input logic [15:0] s, input logic [11:0] c);
        logic [31:0] w;
        if (dig < 4) begin
            if (LZ && dig > 0 && (s >> (dig * 4)) == '0) return 8'hFF;
            return bcd_g(4'(s >> (dig * 4)));
        end
        if (st == 0) begin
            if (dig == 7) return 8'hFF;
            if (LZ && dig > 4 && (c >> ((dig - 4) * 4)) == '0) return 8'hFF;
            return bcd_g(4'(c >> ((dig - 4) * 4)));
        end
        if (st == 2) w = 32'h86AB_A1FF;
        else if (gl == 2'b11) w = 32'h8C86_AF8E;
        else if (gl == 2'b10) w = 32'hC2C0_C0A1;
        else w = 32'h8388_A1FF;
        return 8'(w >> ((dig - 4) * 8));
    endfunction

    initial begin
        int slot, dig, ns;
        bit ev;
        forever begin
            @(posedge clk);
            if (rst) begin
                t = 0; m_state = 0; m_end = 0; m_prev = 2'b00; m_glyph = 2'b00;
                m_ssnap = '0; m_csnap = '0;
                e_seg = 8'hFF; e_com = 8'hFF; e_busy = 1'b0;
            end else begin
                slot = t % SD;
                dig  = (t / SD) % 8;
                if (slot == 0) begin
                    m_ssnap = i_score_bcd;
                    m_csnap = i_combo_bcd;
                end
                e_seg = 8'hFF;
                e_com = 8'hFF;
                if (slot >= BLK) begin
                    e_com = ~(8'h01 << dig);
                    e_seg = model_glyph(dig, m_state, m_glyph, m_ssnap, m_csnap);
                end
                ev = (i_judge != 2'b00) && (i_judge != m_prev);
                m_prev = i_judge;
                if (i_game_over) ns = 2;
                else if (m_state == 2) ns = 0;
                else if (ev) begin
                    ns = 1; m_end = t + BAN; m_glyph = i_judge;
                end else if (m_state == 1 && t >= m_end) ns = 0;
                else ns = m_state;
                m_state = ns;
                e_busy = (ns == 1);
                t++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_seg", o_seg, e_seg);
                chk("model_com", o_com, e_com);
                chk("model_busy", {7'd0, o_busy}, {7'd0, e_busy});
            end
        end
    end

    task automatic wait_com(input logic [7:0] c, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_com == c) begin ok = 1'b1; break; end
        end
        if (!ok) chk({nm, "_timeout"}, 8'h00, 8'h01);
    endtask

    task automatic measure_busy(input logic [7:0] g7, input logic [7:0] g4, input string nm, output int cnt);
        bit s7 = 1'b0, s4 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (i == 0) chk({nm, "_busy_next"}, {7'd0, o_busy}, 8'h01);
            if (o_busy) begin
                cnt++;
                if (cnt >= 2 && o_com == 8'h7F && !s7) begin s7 = 1'b1; chk({nm, "_d7"}, o_seg, g7); end
                if (cnt >= 2 && o_com == 8'hEF && !s4) begin s4 = 1'b1; chk({nm, "_d4"}, o_seg, g4); end
            end else if (cnt > 0) break;
        end
        chk({nm, "_seen"}, {6'd0, s7, s4}, 8'h03);
    endtask

    initial begin
        int cnt;
        bit s;
        rst = 1'b1; i_judge = 2'b00; i_game_over = 1'b0;
        i_score_bcd = 16'h1234; i_combo_bcd = 12'h056;
        repeat (3) @(negedge clk);
        chk("rst_seg", o_seg, 8'hFF);
        chk("rst_com", o_com, 8'hFF);
        chk("rst_busy", {7'd0, o_busy}, 8'h00);
        chk_en = 1'b1;
        rst = 1'b0;

        wait_com(8'hFE, "d0");   chk("score_d0", o_seg, 8'h99);
        wait_com(8'hF7, "d3");   chk("score_d3", o_seg, 8'hF9);
        wait_com(8'hEF, "c4");   chk("combo_d4", o_seg, 8'h82);
        wait_com(8'hBF, "c6");   chk("combo_d6", o_seg, LZ ? 8'hFF : 8'hC0);
        wait_com(8'h7F, "c7");   chk("score_d7", o_seg, 8'hFF);

        i_judge = 2'b11;
        measure_busy(8'h8C, 8'h8E, "perfect", cnt);
        chk("perfect_len", 8'(cnt), 8'(BAN));
        wait_com(8'hEF, "back"); chk("combo_back", o_seg, 8'h82);

        i_judge = 2'b10;
        s = 1'b0;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            if (i >= 2 && o_com == 8'h7F && !s) begin s = 1'b1; chk("normal_d7", o_seg, 8'hC2); end
        end
        i_judge = 2'b01;
        measure_busy(8'h83, 8'hFF, "miss", cnt);
        chk("miss_restart_len", 8'(cnt), 8'(BAN));

        i_judge = 2'b11;
        repeat (5) @(negedge clk);
        i_game_over = 1'b1;
        @(negedge clk);
        chk("final_busy", {7'd0, o_busy}, 8'h00);
        wait_com(8'h7F, "e7");   chk("final_d7", o_seg, 8'h86);
        i_judge = 2'b10;
        @(negedge clk);
        chk("final_ignore_ev", {7'd0, o_busy}, 8'h00);
        wait_com(8'hEF, "e4");   chk("final_d4", o_seg, 8'hFF);
        i_game_over = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_exit_busy", {7'd0, o_busy}, 8'h00);
        wait_com(8'h7F, "s7");   chk("exit_d7", o_seg, 8'hFF);

        wait_com(8'hFB, "d2");
        repeat (2) @(negedge clk);
        i_score_bcd = 16'h9876;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("snap_hold", o_seg, 8'hA4);
        end
        wait_com(8'hF7, "d3n");  chk("snap_new_d3", o_seg, 8'h90);

        i_score_bcd = 16'h1A34;
        wait_com(8'hFB, "nib");  chk("nibble_A", o_seg, 8'hFF);

        i_combo_bcd = 12'h007;
        wait_com(8'h7F, "lzf");
        wait_com(8'hBF, "lz6");  chk("lz_d6", o_seg, LZ ? 8'hFF : 8'hC0);
        wait_com(8'hDF, "lz5");  chk("lz_d5", o_seg, LZ ? 8'hFF : 8'hC0);
        wait_com(8'hEF, "lz4");  chk("lz_d4", o_seg, 8'hF8);

        i_judge = 2'b00;
        @(negedge clk);
        i_judge = 2'b11;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_seg", o_seg, 8'hFF);
        chk("midrst_com", o_com, 8'hFF);
        chk("midrst_busy", {7'd0, o_busy}, 8'h00);
        rst = 1'b0;
        repeat (300) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Scheduler for the 8-digit 7-segment display. It multiplexes three content sources onto one scanned digit bus: the live score, the combo count, and a timed judgement banner (PErF/GOOd/bAd), plus an "End" screen at game over. It runs a blanked scan so adjacent digits do not ghost. It sits between the score/combo counters, the judge logic and the board's o_seg/o_com pins.

## Interface
- SCAN_DIV, 16384: clock cycles per digit slot; must be ≥ BLANK_CYC+2.
- BLANK_CYC, 64: cycles at the start of each slot with all digits off.
- BANNER_CYC, 1000000: banner hold time in cycles; must be ≥ 1.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_judge  in  2  00 none, 01 Miss, 10 Normal, 11 Perfect
- i_score_bcd  in  16  four BCD digits, [15:12] thousands … [3:0] ones
- i_combo_bcd  in  12  three BCD digits, [11:8] hundreds … [3:0] ones
- i_game_over  in  1  level; high selects the End screen
- o_seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}; registered
- o_com  out  8  active-low one-hot digit select, bit0 = rightmost digit; registered
- o_busy  out  1  high while state = BANNER; registered

## Operation
- Reset values: o_seg=8'hFF, o_com=8'hFF, o_busy=0, state=SCORE, slot counter=0, digit index=0, prev_judge=0, banner timer=0.
- Judge event: fires in a cycle where i_judge≠0 and i_judge≠prev_judge. prev_judge<=i_judge every cycle.
- State machine (SCORE, BANNER, FINAL):
  - SCORE→BANNER on an event. The glyph is latched from i_judge and the timer loads BANNER_CYC-1.
  - BANNER→BANNER on a new event: latest event wins; the glyph is replaced and the timer reloads.
  - BANNER→SCORE when the timer is 0 and there is no event in that cycle. The timer decrements otherwise.
  - Any state→FINAL when i_game_over=1. This has priority over events; events in FINAL are ignored.
  - FINAL→SCORE when i_game_over=0.
- Digit map, digits 3..0: score in all states.
- Digit map, digits 7..4 by state:
  - SCORE: digit 7 blank; digits 6..4 show combo.
  - BANNER, Perfect: 8C 86 AF 8E ("PErF").
  - BANNER, Normal: C2 C0 C0 A1 ("GOOd").
  - BANNER, Miss: 83 88 A1 FF ("bAd ").
  - FINAL: 86 AB A1 FF ("End ").
- Digit glyphs 0..9: C0,F9,A4,B0,99,92,82,F8,80,90. A BCD nibble >9 displays FF. dp is always off.
- Snapshot: i_score_bcd and i_combo_bcd are captured when the slot counter is 0. Slot content comes only from the snapshot, so changes mid-slot never tear a digit.

## Timing
- Slot counter runs 0..SCAN_DIV-1 and wraps.
- Digit index increments (mod 8) on each wrap. Order is 0,1,…,7,0.
- Counter < BLANK_CYC: next o_com=FF and o_seg=FF.
- Otherwise: next o_com has a single 0 at the current digit index, and o_seg shows that digit's glyph.
- Outputs are registered, one cycle after the internal counter/state.
- An event in cycle N gives state=BANNER and o_busy=1 in cycle N+1. The glyph appears the next time digits 7..4 are scanned past blanking.
- State changes mid-slot take effect on the next cycle's o_seg; no re-blanking is required.
- One full frame is 8·SCAN_DIV cycles.
- Reset asserted mid-slot or mid-banner: at the next edge all state returns to reset values and the outputs go dark.

## Configuration
- SEG_LZ_BLANK_EN defined: leading-zero blanking.
  - Score digits 3..1 show FF while that digit and all higher score digits are 0; digit 0 is always shown.
  - Combo digits 6..5 are blanked the same way; digit 4 is always shown.
  - Score 0042 shows FF FF 99 A4.
- Not defined: all digits show, including leading zeros (C0 C0 99 A4).

## Test plan
- Reset, then SCAN_DIV=16, BLANK_CYC=2, score 1234: the per-slot o_com sequence is FE,FD,…,7F, all FF in the first 2 cycles of each slot. Digits 3..0 show F9,A4,B0,99.
- i_judge 00→11 held: exactly one event, o_busy=1 the next cycle, digits 7..4 show 8C 86 AF 8E. After BANNER_CYC cycles o_busy=0 and combo returns.
- BANNER Normal, then i_judge→01 mid-banner: glyph becomes 83 88 A1 FF and the timer restarts (o_busy stays high for another BANNER_CYC cycles).
- i_game_over=1 during BANNER: FINAL next cycle, o_busy=0, "End " shown. A judge event while FINAL is ignored. Deassert → SCORE.
- Score input changed at slot count 5 of digit 2: o_seg for that slot is unchanged; the new value appears from the next slot.
- Nibble value A: that digit shows FF. With SEG_LZ_BLANK_EN, combo 007 shows FF FF F8 on digits 6..4.
